// File: rtl/sdram_ex_test_ctrl_if.sv
// Avalon-MM command/response bundle between the SDRAM test controller and memory.
interface sdram_ex_test_ctrl_if #(
   parameter int unsigned ADDR_W = 8
);
   logic [ADDR_W-1:0] avm_address;
   logic              avm_write;
   logic              avm_read;
   logic [7:0]        avm_writedata;
   logic [7:0]        avm_readdata;
   logic              avm_waitrequest;
   logic              avm_readdatavalid;

   modport master (
      output avm_address, avm_write, avm_read, avm_writedata,
      input  avm_readdata, avm_waitrequest, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_write, avm_read, avm_writedata,
      output avm_readdata, avm_waitrequest, avm_readdatavalid
   );
endinterface

// File: rtl/sdram_ex_test_ctrl.sv
// Memory test sequencer: fills 2^ADDR_W words with an lfsr8 pattern, then reads
// them back with up to MAX_OUTST reads in flight and counts mismatches.
module sdram_ex_test_ctrl #(
   parameter int unsigned ADDR_W    = 8,
   parameter logic [31:0] SEED      = 32'd32,
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 lfsr_enable,
   output logic                 lfsr_pause,
   output logic                 lfsr_load,
   output logic [7:0]           lfsr_ldata,
   input  logic [7:0]           lfsr_data,
   sdram_ex_test_ctrl_if.master avm,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [15:0]          fail_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_RELOAD, S_READ, S_DRAIN, S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [2:0]        MAX_O     = 3'(MAX_OUTST);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [2:0]        outst_q, outst_d;
   logic [15:0]       fail_q, fail_d;
   logic              issue;
   logic              rd_phase;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         outst_q <= '0;
         fail_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         outst_q <= outst_d;
         fail_q  <= fail_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      outst_d           = outst_q;
      fail_d            = fail_q;
      issue             = 1'b0;
      lfsr_enable       = 1'b0;
      lfsr_pause        = 1'b0;
      lfsr_load         = 1'b0;
      avm.avm_write     = 1'b0;
      avm.avm_read      = 1'b0;
      avm.avm_address   = cnt_q;
      avm.avm_writedata = lfsr_data;
      rd_phase          = (state_q == S_READ) || (state_q == S_DRAIN);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_WRITE;
               cnt_d   = '0;
               outst_d = '0;
               fail_d  = '0;
            end
         end
         S_WRITE: begin
            lfsr_enable   = 1'b1;
            lfsr_pause    = avm.avm_waitrequest;
            avm.avm_write = 1'b1;
            if (!avm.avm_waitrequest) begin
               cnt_d = cnt_q + ADDR_W'(1);
               if (cnt_q == LAST_ADDR) state_d = S_RELOAD;
            end
         end
         S_RELOAD: begin
            lfsr_enable = 1'b1;
            lfsr_load   = 1'b1;
            state_d     = S_READ;
         end
         S_READ: begin
            lfsr_enable  = 1'b1;
            lfsr_pause   = !avm.avm_readdatavalid;
            avm.avm_read = (outst_q < MAX_O);
            issue        = avm.avm_read && !avm.avm_waitrequest;
            if (issue) begin
               cnt_d = cnt_q + ADDR_W'(1);
               if (cnt_q == LAST_ADDR) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            lfsr_enable = 1'b1;
            lfsr_pause  = !avm.avm_readdatavalid;
         end
         default: state_d = S_IDLE;
      endcase

      // Returns are only meaningful while reading; anything else is a stale response.
      if (rd_phase) begin
         if (issue && !avm.avm_readdatavalid)
            outst_d = outst_q + 3'd1;
         else if (!issue && avm.avm_readdatavalid && outst_q != '0)
            outst_d = outst_q - 3'd1;
         if (avm.avm_readdatavalid && (avm.avm_readdata != lfsr_data) && (fail_q != '1))
            fail_d = fail_q + 16'd1;
         if (state_q == S_DRAIN && outst_d == '0)
            state_d = S_DONE;
      end
   end

   assign lfsr_ldata = SEED[7:0];
   assign busy       = (state_q == S_WRITE) || (state_q == S_RELOAD) || rd_phase;
   assign done       = (state_q == S_DONE);
   assign pass       = done && (fail_q == '0);
   assign fail_count = fail_q;

endmodule

// File: doc/sdram_ex_test_ctrl.md
SDRAM_EX_TEST_CTRL -- requirements
Module: sdram_ex_test_ctrl

Interface
REQ-001 Parameter ADDR_W, 8, word-address width; test covers 2^ADDR_W consecutive words from address 0.
REQ-002 Parameter SEED, 32, LFSR seed; only SEED[7:0] is used and it SHALL match the seed of the attached lfsr8 instance.
REQ-003 Parameter MAX_OUTST, 4, maximum reads in flight (1..7).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a test run.
REQ-007 lfsr_enable, lfsr_pause, lfsr_load  out  1 each  drive the lfsr8 enable/pause/load inputs.
REQ-008 lfsr_ldata  out  8  load value for lfsr8; constant SEED[7:0].
REQ-009 lfsr_data  in  8  current lfsr8 output.
REQ-010 avm_address  out  ADDR_W, avm_write/avm_read  out  1, avm_writedata  out  8  Avalon-MM master command.
REQ-011 avm_readdata  in  8, avm_waitrequest  in  1, avm_readdatavalid  in  1  Avalon-MM slave response.
REQ-012 busy, done, pass  out  1 each; fail_count  out  16  run status.

Function
REQ-013 The block SHALL implement states IDLE, WRITE, RELOAD, READ, DRAIN, DONE.
REQ-014 IDLE/DONE: lfsr_enable=0 (lfsr8 held at seed), avm_write=avm_read=0, busy=0.
REQ-015 start in IDLE or DONE SHALL enter WRITE next cycle, clear fail_count, done and pass, zero the address counter; start in any other state SHALL be ignored.
REQ-016 WRITE: avm_write=1, avm_address=write counter, avm_writedata=lfsr_data, lfsr_pause=avm_waitrequest; a beat is accepted on avm_write && !avm_waitrequest, which increments the counter and advances lfsr8 exactly once.
REQ-017 Acceptance of address 2^ADDR_W-1 SHALL go to RELOAD; counter wraps to 0.
REQ-018 RELOAD: exactly one cycle, lfsr_load=1, no Avalon command; then READ.
REQ-019 READ: avm_read=1 whenever outstanding < MAX_OUTST and issue counter has not passed the last address; issue accepted on avm_read && !avm_waitrequest.
REQ-020 Outstanding counter SHALL +1 on issue, -1 on avm_readdatavalid, unchanged when both occur same cycle.
REQ-021 After last issue accepted go to DRAIN (avm_read=0); DRAIN goes to DONE on the cycle outstanding reaches 0.
REQ-022 In READ/DRAIN lfsr_pause=!avm_readdatavalid; on each readdatavalid, avm_readdata SHALL be compared with lfsr_data and fail_count incremented on mismatch, saturating at 16'hFFFF.
REQ-023 avm_readdatavalid outside READ/DRAIN SHALL be ignored.
REQ-024 busy=1 in WRITE, RELOAD, READ, DRAIN.
REQ-025 DONE: done=1 and pass=(fail_count==0), held until next accepted start or reset.
REQ-026 avm_address/avm_writedata SHALL remain stable while the corresponding command is held against avm_waitrequest.

Reset
REQ-027 On reset=1 at a clock edge, from any state: state=IDLE, counters=0, fail_count=0, done=pass=busy=0, avm_read=avm_write=0, lfsr_enable=lfsr_load=lfsr_pause=0; outstanding reads are abandoned and their returns ignored.

Verification
REQ-028 ADDR_W=2, SEED=32, zero-wait memory: writes addr 0..3 data 8'h20,8'h40,8'h80,8'h1D; readback matches -> done=1, pass=1, fail_count=0.
REQ-029 waitrequest held 3 cycles on write addr 1 -> avm_writedata stays 8'h40, avm_address stays 1, addr 2 gets 8'h80 (no double advance).
REQ-030 Memory returns 8'h81 for addr 2 -> fail_count=1, pass=0, done=1.
REQ-031 readdatavalid latency 6 cycles, MAX_OUTST=4 -> never more than 4 reads outstanding; avm_read low while outstanding=4; all 4 compare correctly.
REQ-032 reset pulsed during READ -> next cycle busy=0, avm_read=0, lfsr_enable=0; late readdatavalid ignored; new start gives clean pass.
REQ-033 start pulsed in WRITE -> ignored; start in DONE -> restarts, done/pass clear next cycle, fail_count=0.
